// File: rtl/syscall_unit.sv
// syscall_unit: console/exit services (print_int, print_string, print_char, exit) for MIPS_SCP.
// Latency: print_char releases stall 2 cycles after decode; print_int/print_string run until done.
// Backpressure: tx_ready low freezes the FSM with tx_valid/tx_data held; stall stays high throughout.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   sc_valid, sc_v0, sc_a0  SYSCALL decode strobe, service code, argument
//   stall, halt, err        PC freeze, sticky exit flag, sticky error flag
//   mem_rd, mem_addr        word read request (data returns one cycle later on mem_rdata)
//   tx_data, tx_valid       console byte stream, transferred when tx_valid & tx_ready
module syscall_unit #(
  parameter int MAX_STR = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sc_valid,
  input  logic [31:0] sc_v0,
  input  logic [31:0] sc_a0,
  output logic        stall,
  output logic        halt,
  output logic        err,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = (MAX_STR < 2) ? 1 : $clog2(MAX_STR + 1);

  typedef enum logic [3:0] {
    IDLE,
    CHAR,
    INT_SIGN,
    INT_DIGIT,
    STR_REQ,
    STR_WAIT,
    STR_EMIT,
    DONE,
    HALTED
  } state_t;

  state_t        r_state;
  logic [32:0]   r_mag;      // remaining magnitude of the integer being printed
  logic [3:0]    r_idx;      // current decimal position (9 = 10^9 ... 0 = units)
  logic [3:0]    r_digit;    // digit accumulated by repeated subtraction
  logic          r_started;  // a non-zero digit has been emitted; zeros are no longer leading
  logic [31:0]   r_ptr;      // byte pointer into the string
  logic [31:0]   r_word;     // word currently being walked
  logic [CW-1:0] r_cnt;      // bytes emitted for this string
  logic          r_halt;
  logic          r_err;
  logic          r_mem_rd;
  logic [31:0]   r_mem_addr;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;

  logic          w_fire;
  logic [32:0]   w_a0_mag;
  logic [32:0]   w_pow;
  logic [7:0]    w_byte;
  logic [31:0]   w_ptr_next;

  function automatic logic [32:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    pow10 = 33'd1;
      4'd1:    pow10 = 33'd10;
      4'd2:    pow10 = 33'd100;
      4'd3:    pow10 = 33'd1000;
      4'd4:    pow10 = 33'd10000;
      4'd5:    pow10 = 33'd100000;
      4'd6:    pow10 = 33'd1000000;
      4'd7:    pow10 = 33'd10000000;
      4'd8:    pow10 = 33'd100000000;
      default: pow10 = 33'd1000000000;
    endcase
  endfunction

  assign w_fire     = r_tx_valid & tx_ready;
  // Two's-complement magnitude; 33 bits keeps -2^31 representable as a positive value.
  assign w_a0_mag   = sc_a0[31] ? ({1'b0, ~sc_a0} + 33'd1) : {1'b0, sc_a0};
  assign w_pow      = pow10(r_idx);
  assign w_byte     = r_word[8*r_ptr[1:0] +: 8];
  assign w_ptr_next = r_ptr + 32'd1;

  // Combinational so the PC is frozen already in the decode cycle.
  assign stall = ((r_state != IDLE) && (r_state != DONE)) || ((r_state == IDLE) && sc_valid);

  assign halt     = r_halt;
  assign err      = r_err;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mag      <= '0;
      r_idx      <= '0;
      r_digit    <= '0;
      r_started  <= 1'b0;
      r_ptr      <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_halt     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sc_valid) begin
            case (sc_v0)
              32'd1: begin
                r_mag     <= w_a0_mag;
                r_idx     <= 4'd9;
                r_digit   <= 4'd0;
                r_started <= 1'b0;
                if (sc_a0[31]) begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= 8'h2D;
                  r_state    <= INT_SIGN;
                end else begin
                  r_state <= INT_DIGIT;
                end
              end
              32'd4: begin
                r_ptr      <= sc_a0;
                r_cnt      <= '0;
                // Raised on entry so mem_rd is high for the whole STR_REQ cycle.
                r_mem_rd   <= 1'b1;
                r_mem_addr <= {sc_a0[31:2], 2'b00};
                r_state    <= STR_REQ;
              end
              32'd10: begin
                r_halt  <= 1'b1;
                r_state <= HALTED;
              end
              32'd11: begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= sc_a0[7:0];
                r_state    <= CHAR;
              end
              default: begin
                r_err   <= 1'b1;
                r_state <= DONE;
              end
            endcase
          end
        end

        CHAR, INT_SIGN: begin
          if (w_fire) begin
            r_tx_valid <= 1'b0;
            r_state    <= (r_state == CHAR) ? DONE : INT_DIGIT;
          end
        end

        INT_DIGIT: begin
          if (r_tx_valid) begin
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
              r_digit    <= 4'd0;
              if (r_idx == 4'd0) begin
                r_state <= DONE;
              end else begin
                r_idx <= r_idx - 4'd1;
              end
            end
          end else if (r_mag >= w_pow) begin
            r_mag   <= r_mag - w_pow;
            r_digit <= r_digit + 4'd1;
          end else if ((r_digit != 4'd0) || r_started || (r_idx == 4'd0)) begin
            // Units digit is always printed so that zero comes out as "0".
            r_tx_valid <= 1'b1;
            r_tx_data  <= 8'h30 + {4'd0, r_digit};
            r_started  <= 1'b1;
          end else begin
            r_idx <= r_idx - 4'd1;
          end
        end

        STR_REQ: begin
          r_mem_rd <= 1'b0;
          r_state  <= STR_WAIT;
        end

        STR_WAIT: begin
          r_word  <= mem_rdata;
          r_state <= STR_EMIT;
        end

        STR_EMIT: begin
          if (r_tx_valid) begin
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
              r_ptr      <= w_ptr_next;
              r_cnt      <= r_cnt + CW'(1);
              if (r_cnt == CW'(MAX_STR - 1)) begin
                r_err   <= 1'b1;
                r_state <= DONE;
              end else if (w_ptr_next[1:0] == 2'b00) begin
                r_mem_rd   <= 1'b1;
                r_mem_addr <= {w_ptr_next[31:2], 2'b00};
                r_state    <= STR_REQ;
              end
            end
          end else if (w_byte == 8'h00) begin
            r_state <= DONE;
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_byte;
          end
        end

        DONE: r_state <= IDLE;

        HALTED: r_state <= HALTED;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: expected console bytes are queued when a call is issued
// and compared as the DUT transfers them; the memory model returns data one cycle after mem_rd.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        sc_valid;
  logic [31:0] sc_v0;
  logic [31:0] sc_a0;
  logic        stall;
  logic        halt;
  logic        err;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  syscall_unit #(.MAX_STR(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sc_valid  (sc_valid),
    .sc_v0     (sc_v0),
    .sc_a0     (sc_a0),
    .stall     (stall),
    .halt      (halt),
    .err       (err),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_tx     = 0;
  int         n_rd     = 0;
  logic [7:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic       held = 1'b0;
  logic [7:0] held_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Data memory: read data valid exactly one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
  end

  // Transfer monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (mem_rd) begin
        n_rd++;
        check("mem_addr_aligned", {62'd0, mem_addr[1:0]}, 64'd0);
      end
      if (held) begin
        check("tx_valid_held", {63'd0, tx_valid}, 64'd1);
        check("tx_data_stable", {56'd0, tx_data}, {56'd0, held_data});
      end
      if (tx_valid && tx_ready) begin
        n_tx++;
        check("tx_expected_pending", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
        held = 1'b0;
      end else if (tx_valid) begin
        held      = 1'b1;
        held_data = tx_data;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Issue one SYSCALL: sc_valid stays high through the stall and the DONE cycle,
  // as the processor keeps decoding the same instruction until stall drops.
  task automatic do_call(input logic [31:0] v0, input logic [31:0] a0, output int sc);
    @(posedge clk); #1;
    sc_valid = 1'b1;
    sc_v0    = v0;
    sc_a0    = a0;
    sc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!stall) break;
      sc++;
    end
    check("call_done", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    sc_valid = 1'b0;
    @(negedge clk);
    check("idle_after_done", {63'd0, stall}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b1;
    sc_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int sc;
    int tx0;
    int rd0;

    reset    = 1'b1;
    sc_valid = 1'b0;
    sc_v0    = '0;
    sc_a0    = '0;
    tx_ready = 1'b1;
    mem[32'h1001_0000] = 32'h6C6C6548;
    mem[32'h1001_0004] = 32'h0000216F;
    mem[32'h2000_0000] = 32'h44434241;
    mem[32'h2000_0004] = 32'h48474645;
    mem[32'h2000_0008] = 32'h4C4B4A49;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",    {63'd0, stall},    64'd0);
    check("rst_halt",     {63'd0, halt},     64'd0);
    check("rst_err",      {63'd0, err},      64'd0);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_mem_rd",   {63'd0, mem_rd},   64'd0);
    check("rst_tx_data",  {56'd0, tx_data},  64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    sc_valid = 1'b1;
    #1 check("rst_stall_follows_sc_valid", {63'd0, stall}, 64'd1);
    sc_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // print_char
    tx0 = n_tx;
    exp_q.push_back(8'h41);
    do_call(32'd11, 32'h41, sc);
    check("char_stall_cycles", 64'(sc), 64'd2);
    check("char_tx_count", 64'(n_tx - tx0), 64'd1);

    // print_int
    push_str("-123");
    do_call(32'd1, 32'hFFFF_FF85, sc);
    tx0 = n_tx;
    push_str("0");
    do_call(32'd1, 32'h0, sc);
    check("int_zero_count", 64'(n_tx - tx0), 64'd1);
    tx0 = n_tx;
    push_str("-2147483648");
    do_call(32'd1, 32'h8000_0000, sc);
    check("int_min_count", 64'(n_tx - tx0), 64'd11);
    push_str("1000000000");
    do_call(32'd1, 32'd1000000000, sc);
    push_str("7");
    do_call(32'd1, 32'd7, sc);

    // print_string, aligned and unaligned
    tx0 = n_tx; rd0 = n_rd;
    push_str("Hello!");
    do_call(32'd4, 32'h1001_0000, sc);
    check("str_tx_count", 64'(n_tx - tx0), 64'd6);
    check("str_reads", 64'(n_rd - rd0), 64'd2);
    tx0 = n_tx; rd0 = n_rd;
    push_str("ello!");
    do_call(32'd4, 32'h1001_0001, sc);
    check("str_unaligned_count", 64'(n_tx - tx0), 64'd5);
    check("str_unaligned_reads", 64'(n_rd - rd0), 64'd2);
    check("err_clear_so_far", {63'd0, err}, 64'd0);

    // tx_ready held low for 20 cycles in the middle of a string
    tx0 = n_tx;
    push_str("Hello!");
    fork
      do_call(32'd4, 32'h1001_0000, sc);
      begin
        for (int i = 0; i < 200 && n_tx < tx0 + 2; i++) @(negedge clk);
        @(posedge clk); #1 tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check("stall_held_no_ready", {63'd0, stall}, 64'd1);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
      end
    join
    check("str_backpressure_count", 64'(n_tx - tx0), 64'd6);

    // Unsupported service code
    tx0 = n_tx;
    do_call(32'd7, 32'h0, sc);
    check("bad_code_err", {63'd0, err}, 64'd1);
    check("bad_code_stall_cycles", 64'(sc), 64'd1);
    check("bad_code_no_tx", 64'(n_tx - tx0), 64'd0);

    // String truncation at MAX_STR (8) bytes
    do_reset();
    check("err_cleared_by_reset", {63'd0, err}, 64'd0);
    tx0 = n_tx; rd0 = n_rd;
    push_str("ABCDEFGH");
    do_call(32'd4, 32'h2000_0000, sc);
    check("trunc_err", {63'd0, err}, 64'd1);
    check("trunc_count", 64'(n_tx - tx0), 64'd8);
    check("trunc_reads", 64'(n_rd - rd0), 64'd2);

    // Reset in the middle of a string aborts it
    tx0 = n_tx;
    push_str("He");
    @(posedge clk); #1;
    sc_valid = 1'b1;
    sc_v0    = 32'd4;
    sc_a0    = 32'h1001_0000;
    for (int i = 0; i < 200 && n_tx < tx0 + 2; i++) @(negedge clk);
    check("rst_mid_progress", 64'(n_tx - tx0), 64'd2);
    @(posedge clk); #1;
    reset    = 1'b1;
    sc_valid = 1'b0;
    #1;
    check("rst_mid_stall",    {63'd0, stall},    64'd0);
    check("rst_mid_err",      {63'd0, err},      64'd0);
    check("rst_mid_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_mid_mem_rd",   {63'd0, mem_rd},   64'd0);
    check("rst_mid_tx_data",  {56'd0, tx_data},  64'd0);
    check("rst_mid_mem_addr", {32'd0, mem_addr}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_more_tx", 64'(n_tx - tx0), 64'd2);
    tx0 = n_tx;
    exp_q.push_back(8'h5A);
    do_call(32'd11, 32'h5A, sc);
    check("post_rst_char_stall", 64'(sc), 64'd2);
    check("post_rst_char_count", 64'(n_tx - tx0), 64'd1);

    // Exit: halted permanently
    tx0 = n_tx;
    @(posedge clk); #1;
    sc_valid = 1'b1;
    sc_v0    = 32'd10;
    sc_a0    = 32'h0;
    @(posedge clk); #1 sc_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("halt_flag",     {63'd0, halt},     64'd1);
    check("halt_stall",    {63'd0, stall},    64'd1);
    check("halt_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("halt_mem_rd",   {63'd0, mem_rd},   64'd0);
    check("halt_no_tx",    64'(n_tx - tx0),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
